// File: rtl/usr_shift_sequencer.sv
// Sequencer that loads a word into a universal shift register, shifts it a commanded
// number of times and captures the result. Optional macro USR_SEQ_ERR_EN adds a sticky err flag.
module usr_shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] q_in,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    SHIFT   = 2'b10,
    CAPTURE = 2'b11
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state;
  state_t           state_next;
  logic [1:0]       sel_next;
  logic             accept;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; sel is decoded from the next state so the output is registered
  always_comb begin
    state_next = state;
    sel_next   = SEL_HOLD;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:    state_next = (cnt != '0) ? SHIFT : CAPTURE;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case (state_next)
      LOAD:    sel_next = SEL_LOAD;
      SHIFT:   sel_next = dir_q ? SEL_RIGHT : SEL_LEFT;
      default: sel_next = SEL_HOLD;
    endcase
  end

  // Command latches, shift counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sel     <= SEL_HOLD;
      ready   <= 1'b1;
      busy    <= 1'b0;
      data_in <= '0;
      dir_q   <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      sel   <= sel_next;
      ready <= (state_next == IDLE);
      busy  <= (state_next != IDLE);
      done  <= 1'b0;
      if (accept) begin
        data_in <= load_data;
        dir_q   <= dir;
        cnt     <= count;
      end
      if (state == SHIFT) cnt <= cnt - CNT_W'(1);
      if (state == CAPTURE) begin
        result <= q_in;
        done   <= 1'b1;
      end
    end
  end

`ifdef USR_SEQ_ERR_EN
  // Sticky flag for a request made while a command is in flight
  always_ff @(posedge clk) begin
    if (reset)               err <= 1'b0;
    else if (start && !ready) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: directed and random commands against a shift-arithmetic model,
// with a behavioural universal shift register closing the loop on q_in.
module tb_usr_shift_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;
`ifdef USR_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] q_in;
  logic             ready;
  logic             busy;
  logic [1:0]       sel;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  int tests  = 0;
  int failed = 0;
  bit exp_err = 1'b0;

  usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .count(count),
    .load_data(load_data), .q_in(q_in), .ready(ready), .busy(busy),
    .sel(sel), .data_in(data_in), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Attached universal shift register, zero fill on the vacated bit
  always @(posedge clk) begin
    if (reset) q_in <= '0;
    else begin
      case (sel)
        2'b01:   q_in <= {q_in[WIDTH-2:0], 1'b0};
        2'b10:   q_in <= {1'b0, q_in[WIDTH-1:1]};
        2'b11:   q_in <= data_in;
        default: q_in <= q_in;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result: word moved n places with zeros shifted in
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] w, input logic d, input int n);
    int v;
    v = int'(w);
    for (int k = 0; k < n; k++) v = d ? (v / 2) : ((v * 2) % (2 ** WIDTH));
    return WIDTH'(v);
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle with start low
  task automatic run_cmd(input logic [WIDTH-1:0] w, input logic d, input int n, input bit noise);
    logic [1:0] shsel;
    shsel     = d ? 2'b10 : 2'b01;
    start     = 1'b1;
    load_data = w;
    dir       = d;
    count     = CNT_W'(n);
    @(negedge clk);
    start     = 1'b0;
    load_data = WIDTH'($urandom);
    dir       = 1'($urandom);
    count     = CNT_W'($urandom);
    check("sel_load", 32'(sel), 32'h3);
    check("busy_load", 32'(busy), 32'h1);
    check("ready_load", 32'(ready), 32'h0);
    check("data_in_load", 32'(data_in), 32'(w));
    for (int i = 2; i <= 2 + n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("sel_seq", 32'(sel), (i <= 1 + n) ? 32'(shsel) : 32'h0);
      check("done_early", 32'(done), 32'h0);
      if (noise && i == 2 && n > 0) begin
        start     = 1'b1;
        load_data = ~w;
        if (ERR_EN) exp_err = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'h1);
    check("result", 32'(result), 32'(model(w, d, n)));
    check("ready_done", 32'(ready), 32'h1);
    check("busy_done", 32'(busy), 32'h0);
    check("sel_done", 32'(sel), 32'h0);
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic idle_cycles(input int n);
    logic [WIDTH-1:0] held;
    held = result;
    repeat (n) begin
      @(negedge clk);
      check("done_clear", 32'(done), 32'h0);
      check("result_hold", 32'(result), 32'(held));
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    dir       = 1'b0;
    count     = '0;
    load_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_data_in", 32'(data_in), 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);

    run_cmd(4'b1010, 1'b0, 1, 1'b0);
    idle_cycles(1);
    run_cmd(4'b1011, 1'b1, 2, 1'b0);
    idle_cycles(1);
    run_cmd(4'b0110, 1'($urandom), 0, 1'b0);
    idle_cycles(1);
    run_cmd(4'b1111, 1'b0, 7, 1'b0);
    run_cmd(4'b0101, 1'b1, 1, 1'b0);
    idle_cycles(1);
    run_cmd(4'b1001, 1'b0, 3, 1'b1);
    idle_cycles(1);

    for (int t = 0; t < 25; t++) begin
      run_cmd(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a shift
    start     = 1'b1;
    load_data = 4'b1111;
    dir       = 1'b0;
    count     = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_sel_shift", 32'(sel), 32'h1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    exp_err = 1'b0;
    check("mid_rst_sel", 32'(sel), 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data_in", 32'(data_in), 32'h0);
    check("mid_rst_result", 32'(result), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    @(negedge clk);
    check("rst_start_ignored", 32'(sel), 32'h0);
    reset = 1'b0;
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'h0);
      check("idle_after_rst", 32'(sel), 32'h0);
    end
    run_cmd(4'b1100, 1'b1, 2, 1'b0);
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
